time_display_scan: RTL and testbench



---
 rtl/time_display_scan.sv | 162 ++++++++++++++++
 tb/tb_time_display_scan.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/time_display_scan.sv
`default_nettype none
// ============================================================================
// Module      : time_display_scan
// Description : Captures hr/min/sec from the 1 Hz domain, converts each field
//               to BCD and multiplexes hh.mm.ss onto six 7-segment digits.
// Revision    : 1.0 - initial release
// ============================================================================
module time_display_scan #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int REFRESH_HZ = 1000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] sec,
    input  logic [5:0] min,
    input  logic [4:0] hr,
    input  logic       blank,
    output logic [5:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int               c_div     = CLK_HZ / REFRESH_HZ;
    localparam int               c_cnt_w   = (c_div > 2) ? $clog2(c_div) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(c_div - 1);
    localparam logic             c_inv     = (ACTIVE_LOW != 0);
    localparam logic [3:0]       c_dash    = 4'hA;
    localparam logic [3:0]       c_off     = 4'hF;

    logic [16:0]        r_s1;
    logic [16:0]        r_s2;
    logic [16:0]        r_shadow;
    logic [c_cnt_w-1:0] r_cnt;
    logic [2:0]         r_idx;
    logic               w_tick;

    logic [7:0]         w_sec_bcd;
    logic [7:0]         w_min_bcd;
    logic [7:0]         w_hr_bcd;
    logic               w_sec_bad;
    logic               w_min_bad;
    logic               w_hr_bad;
    logic [3:0]         w_digit;
    logic [5:0]         w_an;
    logic [6:0]         w_seg;
    logic               w_dp;

    // Value/10 and value%10 by repeated compare-and-subtract (max 63 -> 6 steps).
    function automatic logic [7:0] to_bcd(input logic [5:0] v);
        logic [5:0] rem;
        logic [3:0] tens;
        rem  = v;
        tens = 4'd0;
        for (int i = 0; i < 6; i++) begin
            if (rem >= 6'd10) begin
                rem  = rem - 6'd10;
                tens = tens + 4'd1;
            end
        end
        return {tens, 4'(rem)};
    endfunction

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        logic [6:0] code;
        case (d)
            4'd0:    code = 7'h3F;
            4'd1:    code = 7'h06;
            4'd2:    code = 7'h5B;
            4'd3:    code = 7'h4F;
            4'd4:    code = 7'h66;
            4'd5:    code = 7'h6D;
            4'd6:    code = 7'h7D;
            4'd7:    code = 7'h07;
            4'd8:    code = 7'h7F;
            4'd9:    code = 7'h6F;
            c_dash:  code = 7'h40;
            default: code = 7'h00;
        endcase
        return code;
    endfunction

    // Two-flop capture; shadow only accepts a value seen identically twice.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1     <= 17'd0;
            r_s2     <= 17'd0;
            r_shadow <= 17'd0;
        end else begin
            r_s1 <= {hr, min, sec};
            r_s2 <= r_s1;
            if (r_s1 == r_s2) begin
                r_shadow <= r_s2;
            end
        end
    end

    assign w_tick = (r_cnt == c_cnt_max);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx <= 3'd0;
        end else if (r_idx > 3'd5) begin
            r_idx <= 3'd0;
        end else if (w_tick) begin
            r_idx <= (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;
        end
    end

    always_comb begin
        w_sec_bcd = to_bcd(r_shadow[5:0]);
        w_min_bcd = to_bcd(r_shadow[11:6]);
        w_hr_bcd  = to_bcd({1'b0, r_shadow[16:12]});
        w_sec_bad = (r_shadow[5:0]   > 6'd59);
        w_min_bad = (r_shadow[11:6]  > 6'd59);
        w_hr_bad  = (r_shadow[16:12] > 5'd23);

        w_digit = c_off;
        case (r_idx)
            3'd0:    w_digit = w_sec_bad ? c_dash : w_sec_bcd[3:0];
            3'd1:    w_digit = w_sec_bad ? c_dash : w_sec_bcd[7:4];
            3'd2:    w_digit = w_min_bad ? c_dash : w_min_bcd[3:0];
            3'd3:    w_digit = w_min_bad ? c_dash : w_min_bcd[7:4];
            3'd4:    w_digit = w_hr_bad  ? c_dash : w_hr_bcd[3:0];
            3'd5:    w_digit = w_hr_bad  ? c_dash : w_hr_bcd[7:4];
            default: w_digit = c_off;
        endcase

        w_an  = 6'b000001 << r_idx;
        w_seg = seg_code(w_digit);
        w_dp  = (r_idx == 3'd2) || (r_idx == 3'd4);
        if (blank) begin
            w_an  = 6'd0;
            w_seg = 7'd0;
            w_dp  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an  <= {6{c_inv}};
            seg <= {7{c_inv}};
            dp  <= c_inv;
        end else begin
            an  <= w_an  ^ {6{c_inv}};
            seg <= w_seg ^ {7{c_inv}};
            dp  <= w_dp  ^ c_inv;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_time_display_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_time_display_scan
// Description : Randomised scoreboard bench for time_display_scan (DIV = 6).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_time_display_scan;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic [5:0] sec   = 6'd0;
    logic [5:0] min   = 6'd0;
    logic [4:0] hr    = 5'd0;
    logic       blank = 1'b0;
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;

    int checks = 0;
    int errors = 0;

    logic [13:0] expq[$];
    logic [16:0] hist[$];
    logic [16:0] shadow_m;
    int          n_edge  = 0;
    int          idx_now = 0;

    time_display_scan #(
        .CLK_HZ    (60),
        .REFRESH_HZ(10),
        .ACTIVE_LOW(1)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .sec  (sec),
        .min  (min),
        .hr   (hr),
        .blank(blank),
        .an   (an),
        .seg  (seg),
        .dp   (dp)
    );

    always #5 clk = ~clk;

    // Expected pins for digit d of the displayed time s (active-low, all-off when blanked).
    function automatic logic [13:0] expect_word(int d, logic [16:0] s, logic b);
        logic [6:0] font [10];
        int v, lim, ch;
        logic [6:0] sg;
        logic [5:0] a;
        logic       p;
        font = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        if (b) return 14'h3FFF;
        case (d / 2)
            0:       begin v = int'(s[5:0]);   lim = 59; end
            1:       begin v = int'(s[11:6]);  lim = 59; end
            default: begin v = int'(s[16:12]); lim = 23; end
        endcase
        ch = (d % 2 == 1) ? v / 10 : v % 10;
        sg = (v > lim) ? 7'h40 : font[ch];
        a  = 6'(1 << d);
        p  = (d == 2) || (d == 4);
        return ~{a, sg, p};
    endfunction

    // Displayed value after edge n: the newest sample that was seen on two
    // consecutive edges, no later than edges n-2/n-1. hist[i] holds the sample
    // of edge i-1; hist[0..1] stand for the cleared pre-reset state.
    function automatic logic [16:0] settled(int n);
        for (int i = n - 1; i >= 0; i--) begin
            if (hist[i] == hist[i+1]) return hist[i];
        end
        return 17'd0;
    endfunction

    task automatic chk(string nm, logic [13:0] got, logic [13:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got an=%h seg=%h dp=%b, expected an=%h seg=%h dp=%b",
                     nm, got[13:8], got[7:1], got[0], exp[13:8], exp[7:1], exp[0]);
        end
    endtask

    // Reference model: predicts each edge's output word and pushes it.
    always @(posedge clk) begin
        if (rst) begin
            hist.delete();
            hist.push_back(17'd0);
            hist.push_back(17'd0);
            expq.delete();
            shadow_m = 17'd0;
            n_edge   = 0;
            idx_now  = 0;
        end else begin
            n_edge++;
            expq.push_back(expect_word(((n_edge - 1) / 6) % 6, shadow_m, blank));
            hist.push_back({hr, min, sec});
            shadow_m = settled(n_edge);
            idx_now  = (n_edge / 6) % 6;
        end
    end

    // Monitor: compares the pins against the scoreboard every cycle.
    always @(posedge clk) begin
        #1;
        if (rst) begin
            chk("reset_hold", {an, seg, dp}, 14'h3FFF);
        end else if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: got no expected entry at edge %0d, required one", n_edge);
        end else begin
            chk($sformatf("scan_edge%0d", n_edge), {an, seg, dp}, expq.pop_front());
        end
    end

    task automatic cyc(int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic set_time(int h, int m, int s);
        hr  = 5'(h);
        min = 6'(m);
        sec = 6'(s);
    endtask

    task automatic wait_idx3();
        int t;
        t = 0;
        while (idx_now != 3 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            checks++;
            errors++;
            $display("FAIL wait_idx3: got idx %0d after %0d cycles, required 3", idx_now, t);
        end
    endtask

    initial begin
        cyc(3);
        rst = 1'b0;
        cyc(20);

        set_time(12, 34, 56);
        cyc(80);
        set_time(12, 34, 59);
        cyc(40);
        set_time(12, 34, 60);
        cyc(40);
        set_time(24, 34, 30);
        cyc(40);
        set_time(23, 61, 7);
        cyc(40);

        set_time(0, 0, 5);
        cyc(40);
        sec = 6'd9;
        cyc(1);
        sec = 6'd5;
        cyc(40);
        sec = 6'd9;
        cyc(2);
        cyc(40);

        wait_idx3();
        blank = 1'b1;
        cyc(20);
        blank = 1'b0;
        cyc(20);

        set_time(12, 34, 56);
        cyc(10);
        wait_idx3();
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset", {an, seg, dp}, 14'h3FFF);
        cyc(2);
        rst = 1'b0;
        cyc(50);

        repeat (300) begin
            set_time($urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 63));
            blank = ($urandom_range(0, 9) == 0);
            cyc($urandom_range(1, 4));
        end
        blank = 1'b0;
        cyc(40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
